booth_mult_seq: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier with integrated controller.

---
 rtl/booth_mult_seq.sv | 145 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier (signed/unsigned) with
//            start/done handshake. Optional BOOTH_HALF_OUT_EN adds a
//            half_sel/half_out port pair for narrow result buses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 busy,
    output logic                 done,
`ifdef BOOTH_HALF_OUT_EN
    output logic [2*WIDTH-1:0]   product,
    input  logic                 half_sel,
    output logic [WIDTH-1:0]     half_out
`else
    output logic [2*WIDTH-1:0]   product
`endif
);

    localparam int M  = WIDTH + 1;
    localparam int CW = $clog2(M + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(M);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [M-1:0]    a_reg;
    logic [M-1:0]    x_reg;
    logic [M-1:0]    y_reg;
    logic            e_reg;
    logic [CW-1:0]   count;

    logic            load;
    logic            iterate;
    logic            finish;
    logic [M-1:0]    x_ext;
    logic [M-1:0]    y_ext;
    logic [M-1:0]    sum;

    // One extra operand bit lets the same signed Booth recoding serve unsigned inputs.
    always_comb begin
        x_ext = {is_signed & x_in[WIDTH-1], x_in};
        y_ext = {is_signed & y_in[WIDTH-1], y_in};
    end

    always_comb begin
        sum = a_reg;
        case ({x_reg[0], e_reg})
            2'b10:   sum = a_reg - y_reg;
            2'b01:   sum = a_reg + y_reg;
            default: sum = a_reg;
        endcase
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                // Last CALC cycle (count exhausted) only latches the product.
                if (count != '0) begin
                    iterate = 1'b1;
                end else begin
                    finish     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = S_CALC;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            e_reg   <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                y_reg <= y_ext;
                x_reg <= x_ext;
                a_reg <= '0;
                e_reg <= 1'b0;
                count <= COUNT_INIT;
            end else if (iterate) begin
                a_reg <= {sum[M-1], sum[M-1:1]};
                x_reg <= {sum[0], x_reg[M-1:1]};
                e_reg <= x_reg[0];
                count <= count - COUNT_ONE;
            end
            if (finish) begin
                product <= {a_reg[WIDTH-2:0], x_reg};
            end
        end
    end

`ifdef BOOTH_HALF_OUT_EN
    always_comb begin
        half_out = half_sel ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: randomized and directed operations checked by a
// queue-based scoreboard against a plain-arithmetic reference.
`default_nettype none

module tb_booth_mult_seq;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   x_in = '0;
    logic [W-1:0]   y_in = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef BOOTH_HALF_OUT_EN
    logic           half_sel = 1'b0;
    logic [W-1:0]   half_out;
`endif

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
`ifdef BOOTH_HALF_OUT_EN
        .product   (product),
        .half_sel  (half_sel),
        .half_out  (half_out)
`else
        .product   (product)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t q[$];

    function automatic logic [2*W-1:0] ref_mul(bit s, logic [W-1:0] x, logic [W-1:0] y);
        longint a;
        longint b;
        longint p;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'(x);
            b = longint'(y);
        end
        p = a * b;
        return p[2*W-1:0];
    endfunction

    // Monitor: pops on every done pulse, otherwise product must hold its last value.
    logic [2*W-1:0] last_prod = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_prod = '0;
        end else if (done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: product=%h at cycle %0d, none expected", product, cyc);
                last_prod = product;
            end else begin
                e = q.pop_front();
                if (product !== e.prod || (cyc - e.cyc) != LAT) begin
                    failures++;
                    $display("FAIL result: product=%h latency=%0d, required product=%h latency=%0d",
                             product, cyc - e.cyc, e.prod, LAT);
                end
                last_prod = e.prod;
            end
        end else begin
            checks++;
            if (product !== last_prod) begin
                failures++;
                $display("FAIL product_hold: product=%h, required %h at cycle %0d", product, last_prod, cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle: busy=%b, required 0 within 200 cycles", busy);
        end
    endtask

    task automatic issue(bit s, logic [W-1:0] x, logic [W-1:0] y, bit hold);
        exp_t e;
        wait_idle();
        is_signed = s;
        x_in      = x;
        y_in      = y;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e.prod = ref_mul(s, x, y);
        e.cyc  = cyc;
        q.push_back(e);
        if (!hold) start = 1'b0;
        x_in = W'($urandom);
        y_in = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   n;

        repeat (3) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: done=%b, required 0", done); end
        if (product !== '0) begin failures++; $display("FAIL reset_product: product=%h, required 0", product); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors including most-negative and all-ones operands
        issue(1'b1, 8'h05, 8'hFD, 1'b0);
        drain();
        issue(1'b1, 8'h80, 8'h80, 1'b0);
        drain();
        issue(1'b0, 8'hFF, 8'hFF, 1'b0);
        drain();
`ifdef BOOTH_HALF_OUT_EN
        half_sel = 1'b1;
        #1;
        checks++;
        if (half_out !== 8'hFE) begin failures++; $display("FAIL half_hi: half_out=%h, required fe", half_out); end
        half_sel = 1'b0;
        #1;
        checks++;
        if (half_out !== 8'h01) begin failures++; $display("FAIL half_lo: half_out=%h, required 01", half_out); end
`endif
        issue(1'b1, 8'h00, 8'h80, 1'b0);
        issue(1'b0, 8'hA7, 8'h00, 1'b0);
        issue(1'b1, 8'h7F, 8'h80, 1'b0);
        drain();

        // Start pulsed mid-CALC with new operands must be ignored
        issue(1'b1, 8'h13, 8'hE9, 1'b0);
        repeat (2) @(negedge clk);
        x_in = 8'h55; y_in = 8'h66; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (LAT) @(negedge clk);

        // Start held across DONE: second op accepted in the DONE cycle
        issue(1'b0, 8'hC3, 8'h5A, 1'b1);
        is_signed = 1'b1; x_in = 8'h9C; y_in = 8'h37;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        e.prod = ref_mul(1'b1, 8'h9C, 8'h37);
        e.cyc  = cyc;
        q.push_back(e);
        start = 1'b0;
        drain();

        // Reset mid-CALC aborts with no done pulse
        is_signed = 1'b1; x_in = 8'h21; y_in = 8'h43; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: busy=%b, required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL abort_done: done=%b, required 0", done); end
        if (product !== '0) begin failures++; $display("FAIL abort_product: product=%h, required 0", product); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);

        // Randomized operations, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), W'($urandom), W'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
